// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the three write-back requesters, the register-file read
// port, and the write arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [3*ADDR_W-1:0] req_reg;
  logic [3*DATA_W-1:0] req_data;
  logic                lock;
  logic                reg_write;
  logic [ADDR_W-1:0]   write_reg;
  logic [DATA_W-1:0]   write_data;
  logic [ADDR_W-1:0]   read_reg1;
  logic [ADDR_W-1:0]   read_reg2;
  logic                fwd1_hit;
  logic                fwd2_hit;
  logic [7:0]          drop_cnt;

  modport master (
    output req_valid, req_reg, req_data, lock, read_reg1, read_reg2,
    input  req_ready, reg_write, write_reg, write_data, fwd1_hit, fwd2_hit, drop_cnt
  );

  modport slave (
    input  req_valid, req_reg, req_data, lock, read_reg1, read_reg2,
    output req_ready, reg_write, write_reg, write_data, fwd1_hit, fwd2_hit, drop_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging three write-back requesters into one registered
// register-file write port, with r0 writes dropped and counted, plus forwarding.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  logic [1:0]        rr_ptr;
  logic [1:0]        idx0, idx1, idx2;
  logic [1:0]        grant_idx;
  logic [2:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic              vld_p1;
  logic [ADDR_W-1:0] write_reg_p1;
  logic [DATA_W-1:0] write_data_p1;
  logic [7:0]        drop_cnt_q;

  function automatic logic [1:0] wrap_inc(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Search order starts at the pointer; the unreachable code 3 folds onto 0.
  always_comb begin
    idx0 = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
    idx1 = wrap_inc(idx0);
    idx2 = wrap_inc(idx1);
  end

  always_comb begin
    grant     = 3'b000;
    grant_idx = 2'd0;
    if (!rst && !bus.lock) begin
      if (bus.req_valid[idx0]) begin
        grant_idx   = idx0;
        grant[idx0] = 1'b1;
      end else if (bus.req_valid[idx1]) begin
        grant_idx   = idx1;
        grant[idx1] = 1'b1;
      end else if (bus.req_valid[idx2]) begin
        grant_idx   = idx2;
        grant[idx2] = 1'b1;
      end
    end
  end

  // Grants are only raised on valid requesters, so any grant is a transfer.
  assign xfer = |grant;

  always_comb begin
    case (grant_idx)
      2'd1: begin
        sel_reg  = bus.req_reg[ADDR_W +: ADDR_W];
        sel_data = bus.req_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_reg  = bus.req_reg[2*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        sel_reg  = bus.req_reg[0 +: ADDR_W];
        sel_data = bus.req_data[0 +: DATA_W];
      end
    endcase
  end

  // Stage p0 -> p1: register the granted write or count a dropped r0 write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= 2'd0;
      vld_p1        <= 1'b0;
      write_reg_p1  <= '0;
      write_data_p1 <= '0;
      drop_cnt_q    <= 8'd0;
    end else begin
      vld_p1 <= 1'b0;
      if (xfer) begin
        rr_ptr <= wrap_inc(grant_idx);
        if (sel_reg != '0) begin
          vld_p1        <= 1'b1;
          write_reg_p1  <= sel_reg;
          write_data_p1 <= sel_data;
        end else begin
          drop_cnt_q <= sat_inc8(drop_cnt_q);
        end
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.reg_write  = vld_p1;
  assign bus.write_reg  = write_reg_p1;
  assign bus.write_data = write_data_p1;
  assign bus.drop_cnt   = drop_cnt_q;

  assign bus.fwd1_hit = !rst && vld_p1 && (bus.read_reg1 == write_reg_p1) && (bus.read_reg1 != '0);
  assign bus.fwd2_hit = !rst && vld_p1 && (bus.read_reg2 == write_reg_p1) && (bus.read_reg2 != '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_ptr;
  logic        m_wr;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
  int          m_cnt;
  logic [2:0]  m_xfer;
  int          m_wait [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int ptr, input logic [2:0] v);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (ptr + k) % 3;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready();
    int g;
    if (rst || bus.lock) return 3'b000;
    g = pick(m_ptr, bus.req_valid);
    if (g < 0) return 3'b000;
    return 3'(1 << g);
  endfunction

  // Model update on each rising edge
  always @(posedge clk) begin
    int g;
    m_xfer = 3'b000;
    if (rst) begin
      m_ptr = 0; m_wr = 1'b0; m_wreg = '0; m_wdata = '0; m_cnt = 0;
      for (int i = 0; i < 3; i++) m_wait[i] = 0;
    end else begin
      g = bus.lock ? -1 : pick(m_ptr, bus.req_valid);
      for (int i = 0; i < 3; i++) begin
        if (!bus.req_valid[i]) m_wait[i] = 0;
        else if (!bus.lock) begin
          if (i == g) begin
            chk($sformatf("starve%0d", i), 64'(m_wait[i] + 1 <= 3), 64'd1);
            m_wait[i] = 0;
          end else m_wait[i]++;
        end
      end
      m_wr = 1'b0;
      if (g >= 0) begin
        m_xfer[g] = 1'b1;
        m_ptr = (g + 1) % 3;
        if (bus.req_reg[g*AW +: AW] != 0) begin
          m_wr = 1'b1;
          m_wreg = bus.req_reg[g*AW +: AW];
          m_wdata = bus.req_data[g*DW +: DW];
        end else if (m_cnt < 255) m_cnt++;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready()));
    chk("reg_write", 64'(bus.reg_write), 64'(m_wr));
    chk("write_reg", 64'(bus.write_reg), 64'(m_wreg));
    chk("write_data", 64'(bus.write_data), 64'(m_wdata));
    chk("drop_cnt", 64'(bus.drop_cnt), 64'(m_cnt));
    chk("fwd1_hit", 64'(bus.fwd1_hit),
        64'(!rst && m_wr && bus.read_reg1 == m_wreg && bus.read_reg1 != 0));
    chk("fwd2_hit", 64'(bus.fwd2_hit),
        64'(!rst && m_wr && bus.read_reg2 == m_wreg && bus.read_reg2 != 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    bus.req_valid[i] = v;
    bus.req_reg[i*AW +: AW] = r;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
    bus.req_reg = '0;
    bus.req_data = '0;
    bus.lock = 1'b0;
    bus.read_reg1 = '0;
    bus.read_reg2 = '0;
  endtask

  initial begin
    logic [2:0] rdy_seq [4];
    logic [AW-1:0] wr_seq [4];
    rdy_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    wr_seq  = '{5'd1, 5'd2, 5'd3, 5'd1};

    // Reset with all requesters valid: nothing may be granted
    rst = 1'b1;
    clear_all();
    set_req(0, 1'b1, 5'd1, 32'hA0);
    set_req(1, 1'b1, 5'd2, 32'hA1);
    set_req(2, 1'b1, 5'd3, 32'hA2);
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_reg_write", 64'(bus.reg_write), 64'd0);
    chk("rst_write_reg", 64'(bus.write_reg), 64'd0);
    chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    tick();
    rst = 1'b0;

    // Round robin with all three continuously valid
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) chk($sformatf("rr_ready%0d", k), 64'(bus.req_ready), 64'(rdy_seq[k]));
      if (k >= 1) begin
        chk($sformatf("rr_wr%0d", k), 64'(bus.reg_write), 64'd1);
        chk($sformatf("rr_wreg%0d", k), 64'(bus.write_reg), 64'(wr_seq[k-1]));
      end
      tick();
    end

    // r0 writes are dropped and counted
    rst = 1'b1;
    clear_all();
    tick();
    rst = 1'b0;
    set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
    tick(); tick(); tick();
    clear_all();
    @(negedge clk);
    chk("r0_drop_cnt", 64'(bus.drop_cnt), 64'd3);
    chk("r0_reg_write", 64'(bus.reg_write), 64'd0);

    // Forwarding of the just-written register
    set_req(0, 1'b1, 5'd5, 32'h12345678);
    tick();
    clear_all();
    bus.read_reg1 = 5'd5;
    bus.read_reg2 = 5'd0;
    @(negedge clk);
    chk("fwd_hit1", 64'(bus.fwd1_hit), 64'd1);
    chk("fwd_hit2", 64'(bus.fwd2_hit), 64'd0);
    chk("fwd_data", 64'(bus.write_data), 64'h12345678);
    tick();

    // Lock holds off all grants; release resumes at the pointer (now 1)
    clear_all();
    set_req(0, 1'b1, 5'd1, 32'hB0);
    set_req(1, 1'b1, 5'd2, 32'hB1);
    set_req(2, 1'b1, 5'd3, 32'hB2);
    bus.lock = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("lock_ready%0d", k), 64'(bus.req_ready), 64'd0);
      if (k >= 1) chk($sformatf("lock_wr%0d", k), 64'(bus.reg_write), 64'd0);
      tick();
    end
    bus.lock = 1'b0;
    @(negedge clk);
    chk("unlock_ready", 64'(bus.req_ready), 64'b010);
    tick();

    // Reset right after a grant of r7 discards the in-flight write
    clear_all();
    set_req(0, 1'b1, 5'd7, 32'h77);
    tick();
    clear_all();
    rst = 1'b1;
    @(negedge clk);
    chk("inflight_wreg", 64'(bus.write_reg), 64'd7);
    tick();
    rst = 1'b0;
    set_req(1, 1'b1, 5'd9, 32'h99);
    set_req(2, 1'b1, 5'd10, 32'hAA);
    @(negedge clk);
    chk("postrst_wr", 64'(bus.reg_write), 64'd0);
    chk("postrst_cnt", 64'(bus.drop_cnt), 64'd0);
    chk("postrst_ready", 64'(bus.req_ready), 64'b010);
    tick();
    clear_all();

    // Randomized traffic; requesters hold their request until granted
    for (int c = 0; c < 600; c++) begin
      tick();
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) begin
        if (bus.req_valid[i] && m_xfer[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'b1, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)), $urandom);
      end
      bus.lock = ($urandom_range(0, 7) == 0);
      bus.read_reg1 = 5'($urandom_range(0, 31));
      bus.read_reg2 = (m_wr && $urandom_range(0, 1) == 1) ? m_wreg : 5'($urandom_range(0, 31));
    end

    // Saturation of the drop counter
    tick();
    rst = 1'b1;
    clear_all();
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 5'd0, 32'h0);
    for (int c = 0; c < 300; c++) tick();
    clear_all();
    @(negedge clk);
    chk("sat_drop_cnt", 64'(bus.drop_cnt), 64'd255);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register index width.
Ports:
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 3, per-requester write request (bit0 ALU writeback, bit1 load writeback, bit2 debug/init).
REQ-006 The block SHALL have port req_ready, output, 3, per-requester grant (combinational).
REQ-007 The block SHALL have port req_reg, input, 3*ADDR_W, destination index; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port req_data, input, 3*DATA_W, write data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port lock, input, 1, which blocks all grants while high.
REQ-010 The block SHALL have port reg_write, output, 1, registered write enable to the register file.
REQ-011 The block SHALL have port write_reg, output, ADDR_W, registered write index.
REQ-012 The block SHALL have port write_data, output, DATA_W, registered write data.
REQ-013 The block SHALL have port read_reg1 and read_reg2, input, ADDR_W each, read indices also presented to the register file.
REQ-014 The block SHALL have port fwd1_hit and fwd2_hit, output, 1 each, combinational forward-select flags.
REQ-015 The block SHALL have port drop_cnt, output, 8, count of accepted writes to r0.

Function
REQ-016 The block SHALL hold a 2-bit round-robin pointer rr_ptr with values 0..2; value 3 is unreachable.
REQ-017 The block SHALL grant exactly one requester per cycle when lock=0 and any req_valid bit is set; it SHALL grant none otherwise.
REQ-018 The block SHALL select the grant as the first valid requester searching from rr_ptr upward, wrapping 2->0.
REQ-019 The block SHALL drive req_ready as one-hot on the granted requester and zero elsewhere; req_ready SHALL depend on req_valid, rr_ptr and lock only.
REQ-020 A transfer SHALL occur on a cycle where req_valid[i]=1 and req_ready[i]=1.
REQ-021 On a transfer from requester i, the block SHALL set rr_ptr to (i+1) mod 3 at the next edge; rr_ptr SHALL otherwise hold.
REQ-022 On a transfer with a nonzero index, the block SHALL, at the next edge, set reg_write=1 and load write_reg and write_data from requester i (1-cycle latency).
REQ-023 On a transfer with index 0, the block SHALL, at the next edge, set reg_write=0 and increment drop_cnt; drop_cnt SHALL saturate at 255.
REQ-024 The block SHALL deassert reg_write at the next edge in any cycle without a transfer; write_reg and write_data SHALL hold their values.
REQ-025 The block SHALL assert fwdN_hit when reg_write=1, read_regN==write_reg and read_regN!=0; the consumer then uses write_data in place of the register-file read data.
REQ-026 A requester SHALL hold req_valid, req_reg and req_data stable until it is granted; the block SHALL NOT rely on a requester withdrawing.
REQ-027 When lock rises while requests are pending, no grant SHALL occur; a write already in the output register SHALL still complete on its cycle.
REQ-028 Starvation bound: a continuously valid requester SHALL be granted within 3 cycles of unlocked operation.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL load rr_ptr=0, reg_write=0, write_reg=0, write_data=0 and drop_cnt=0.
REQ-030 While rst=1, req_ready SHALL be 0 and fwd1_hit and fwd2_hit SHALL be 0.
REQ-031 An in-flight write in the output register SHALL be discarded when rst is asserted mid-operation.

Verification
REQ-032 All three valid continuously (indices 1, 2, 3) after reset -> grants in order 0, 1, 2, 0; reg_write=1 every cycle from cycle 2; write_reg sequence 1, 2, 3, 1.
REQ-033 Requester 1 only, req_reg=0, data=0xDEADBEEF, over 3 cycles -> reg_write stays 0 and drop_cnt=3.
REQ-034 Requester 0 writes r5=0x12345678 with read_reg1=5 and read_reg2=0 on the following cycle -> fwd1_hit=1, fwd2_hit=0 and write_data=0x12345678.
REQ-035 lock=1 for 4 cycles with all requesters valid -> req_ready=000 and reg_write=0 after the first cycle; on release, the grant goes to the requester at rr_ptr.
REQ-036 rst pulsed for 1 cycle in the cycle after a grant of r7 -> reg_write=0, drop_cnt=0 and rr_ptr=0; the next grant goes to the lowest valid index.
REQ-037 Running 300 r0 writes -> drop_cnt saturates at 255 and never wraps.
